seq_shr: RTL
============

// Module: seq_shr
// PURPOSE
//  Multi-cycle right shifter; the right-shift counterpart of the SHL datapath component.
//  Trades the full barrel shifter for a small STEP-bit shifter, iterated over several cycles.
//  Uses valid/ready handshakes on the operand and result sides.
//  Sits in scheduled datapaths where a SHR op may take multiple cycles.
// PARAMETERS
//  DATAWIDTH  32  width of a, sh_amt and d
//  STEP       4   max bits shifted per cycle; power of 2, 1..DATAWIDTH
// PORTS
//  clk        in   1          clock; all state updates on posedge
//  rst        in   1          synchronous, active-high reset
//  in_valid   in   1          operand pair a/sh_amt valid
//  in_ready   out  1          block can accept an operand pair
//  a          in   DATAWIDTH  value to shift
//  sh_amt     in   DATAWIDTH  shift amount, unsigned
//  out_valid  out  1          result d valid
//  out_ready  in   1          consumer accepts d
//  d          out  DATAWIDTH  shifted result
//  busy       out  1          high in SHIFT or DONE (state != IDLE)
// BEHAVIOUR
//  - Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, d=0, internal remaining count=0.
//  - rst overrides everything, including a handshake in progress; any operation is dropped.
//  - IDLE: in_ready=1. On accept (in_valid & in_ready):
//      data reg <= a; rem <= min(sh_amt, DATAWIDTH) (saturate; compare full sh_amt width).
//      Next state is SHIFT if rem != 0, else DONE.
//  - SHIFT: each edge: k = min(rem, STEP); data reg <= data reg >> k; rem <= rem - k.
//      When rem - k == 0, next state is DONE. in_ready=0. in_valid is ignored.
//  - DONE: out_valid=1; d holds the data reg, stable until the handshake completes.
//      On out_valid & out_ready, next state is IDLE and out_valid is cleared the next cycle.
//      No new operand is accepted in the same cycle (in_ready=0 in DONE).
//  - Latency from accept edge to out_valid=1: 1 + ceil(min(sh_amt,DATAWIDTH)/STEP) edges.
//    sh_amt=0 gives 1 edge and d=a.
//  - Throughput: one operation per latency+1 cycles, at best.
//  - d is registered; d is 0 until the first result and keeps the last result in IDLE.
//  - sh_amt >= DATAWIDTH: every bit is shifted out, so d is all fill bits.
// CONFIGURATION
//  - Macro SEQ_SHR_ARITH_EN defined: arithmetic shift.
//      Fill bit is a[DATAWIDTH-1], captured at accept; vacated MSBs replicate it.
//  - Macro not defined: logical shift; fill bit is 0.
//  - The port list is identical in both builds.
// STRUCTURE
//  - Shared header seq_shr_pkg.vh:
//      localparams S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2;
//      clog2 function to size rem ($clog2(DATAWIDTH+1) bits).
//  - Sub-module shr_step: combinational shift of DATAWIDTH bits by 0..STEP, with a fill input.
//  - Top level holds the FSM, data/rem/fill registers and handshake logic.
// TESTING (DATAWIDTH=32, STEP=4; use clk_gen, rst_gen, error_monitor)
//  1. a=0x8000_0001, sh_amt=0
//     -> d=0x8000_0001, out_valid 1 edge after accept.
//  2. a=0xF000_0000, sh_amt=5
//     -> d=0x0780_0000 (ARITH_EN: 0xFF80_0000), out_valid 3 edges after accept.
//  3. a=0x8000_0000, sh_amt=40
//     -> d=0x0000_0000 (ARITH_EN: 0xFFFF_FFFF), latency 9 edges.
//  4. out_ready held low 5 cycles in DONE, in_valid=1 throughout
//     -> d and out_valid stable, in_ready=0, no second accept.
//  5. rst pulsed mid-SHIFT with sh_amt=20
//     -> next cycle out_valid=0, d=0, in_ready=1, busy=0.
//  6. 10k random a, sh_amt in 0..DATAWIDTH+8, random out_ready
//     -> d matches the a>>sh_amt model (>>> under ARITH_EN); latency formula holds.

Source files
------------

// File: rtl/seq_shr_pkg.sv
// Shared declarations for the multi-cycle right shifter: FSM state encoding
// and a constant-evaluable ceil(log2) used to size the remaining-count register.
package seq_shr_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } seq_shr_state_e;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

endpackage

// File: rtl/seq_shr_step.sv
// Combinational right shift of DATAWIDTH bits by 0..STEP positions; vacated
// MSBs are loaded from the fill input.
module shr_step #(
   parameter int DATAWIDTH = 32,
   parameter int STEP      = 4,
   parameter int KW        = 3
) (
   input  logic [DATAWIDTH-1:0] data,
   input  logic [KW-1:0]        amt,
   input  logic                 fill,
   output logic [DATAWIDTH-1:0] y
);

   logic [2*DATAWIDTH-1:0] ext;
   logic [2*DATAWIDTH-1:0] shifted;

   // Fill bits sit above the data so a plain logical shift brings them in.
   assign ext     = {{DATAWIDTH{fill}}, data};
   assign shifted = ext >> amt;
   assign y       = shifted[DATAWIDTH-1:0];

endmodule

// File: rtl/seq_shr.sv
// Multi-cycle right shifter with valid/ready operand and result handshakes.
// Define SEQ_SHR_ARITH_EN for an arithmetic shift; default is logical.
module seq_shr
   import seq_shr_pkg::*;
#(
   parameter int DATAWIDTH = 32,
   parameter int STEP      = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATAWIDTH-1:0] a,
   input  logic [DATAWIDTH-1:0] sh_amt,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATAWIDTH-1:0] d,
   output logic                 busy
);

   // Handshake rule: a transfer happens on a rising edge where valid and ready
   // are both high; valid never depends on ready, and payloads are held until taken.

   localparam int RW = clog2(DATAWIDTH + 1);
   localparam int KW = clog2(STEP + 1);
   localparam logic [DATAWIDTH-1:0] DW_FULL = DATAWIDTH'(DATAWIDTH);

   seq_shr_state_e         state_q, state_n;
   logic [DATAWIDTH-1:0]   data_q;
   logic [DATAWIDTH-1:0]   d_q;
   logic [RW-1:0]          rem_q;
   logic [RW-1:0]          rem_init;
   logic [KW-1:0]          k;
   logic                   fill;
   logic [DATAWIDTH-1:0]   step_y;
   logic                   accept;
   logic                   last_step;

`ifdef SEQ_SHR_ARITH_EN
   logic fill_q;
   always_ff @(posedge clk) begin
      if (rst)         fill_q <= 1'b0;
      else if (accept) fill_q <= a[DATAWIDTH-1];
   end
   assign fill = fill_q;
`else
   assign fill = 1'b0;
`endif

   assign accept    = (state_q == S_IDLE) && in_valid;
   // Saturate against the full sh_amt width so large amounts are not aliased.
   assign rem_init  = (sh_amt >= DW_FULL) ? RW'(DATAWIDTH) : RW'(sh_amt);
   assign k         = (rem_q < RW'(STEP)) ? KW'(rem_q) : KW'(STEP);
   assign last_step = (rem_q == RW'(k));

   shr_step #(
      .DATAWIDTH(DATAWIDTH),
      .STEP     (STEP),
      .KW       (KW)
   ) u_step (
      .data(data_q),
      .amt (k),
      .fill(fill),
      .y   (step_y)
   );

   always_comb begin
      state_n = state_q;
      case (state_q)
         S_IDLE:  if (in_valid) state_n = (rem_init != '0) ? S_SHIFT : S_DONE;
         S_SHIFT: if (last_step) state_n = S_DONE;
         S_DONE:  if (out_ready) state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_n;
   end

   // d is written only when the final value is known, so it stays stable in DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
         rem_q  <= '0;
         d_q    <= '0;
      end else if (accept) begin
         data_q <= a;
         rem_q  <= rem_init;
         if (rem_init == '0) d_q <= a;
      end else if (state_q == S_SHIFT) begin
         data_q <= step_y;
         rem_q  <= rem_q - RW'(k);
         if (last_step) d_q <= step_y;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign d         = d_q;

endmodule
